// File: rtl/accel_spi_reader.sv
// SPI master for the ADXL362: one POWER_CTL write after startup, then periodic X/Y burst reads.
// Build option: ACCEL_SMOOTH_EN averages each new raw sample with the previous one.
module accel_spi_reader #(
   parameter int CLK_DIV        = 9,
   parameter int STARTUP_CYCLES = 180000,
   parameter int SAMPLE_PERIOD  = 360000,
   parameter int CS_GUARD       = 18
) (
   input  logic       pixel_clk,
   input  logic       rst_n,
   input  logic       spi_miso,
   output logic       spi_sclk,
   output logic       spi_mosi,
   output logic       spi_cs_n,
   output logic [7:0] accel_data_x,
   output logic [7:0] accel_data_y,
   output logic       data_valid,
   output logic       init_done
);

   localparam int CNT_MAX = (STARTUP_CYCLES > CS_GUARD) ? STARTUP_CYCLES : CS_GUARD;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int TW      = $clog2(SAMPLE_PERIOD + 1);
   localparam int DW      = $clog2(CLK_DIV + 1);

   localparam logic [31:0] INIT_FRAME = 32'h0A2D_0200;
   localparam logic [31:0] RD_FRAME   = 32'h0B08_0000;

   typedef enum logic [2:0] {STARTUP, INIT_XFER, GAP, IDLE, RD_XFER, LATCH} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic [TW-1:0]  tmr;
   logic [DW-1:0]  div;
   logic [6:0]     ph;
   logic [31:0]    tx;
   logic [15:0]    rx;
   logic           pending;
   logic           start, xfer, tick, last_ph, xfer_done, expire;
   logic [31:0]    frame;
   logic [7:0]     new_x, new_y;

   assign xfer      = (state == INIT_XFER) || (state == RD_XFER);
   assign tick      = (div == DW'(CLK_DIV - 1));
   // A transfer is 2N+1 half-periods: N low/high pairs plus a trailing low before cs_n rises.
   assign last_ph   = (ph == ((state == INIT_XFER) ? 7'd48 : 7'd64));
   assign xfer_done = xfer && tick && last_ph;
   assign expire    = init_done && (tmr == TW'(SAMPLE_PERIOD - 1));
   assign frame     = (state == IDLE) ? RD_FRAME : INIT_FRAME;

`ifdef ACCEL_SMOOTH_EN
   logic [7:0]        prev_x, prev_y;
   logic signed [8:0] sum_x, sum_y;

   assign sum_x = $signed({prev_x[7], prev_x}) + $signed({rx[15], rx[15:8]});
   assign sum_y = $signed({prev_y[7], prev_y}) + $signed({rx[7], rx[7:0]});
   assign new_x = 8'(sum_x >>> 1);
   assign new_y = 8'(sum_y >>> 1);

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_x <= 8'h00;
         prev_y <= 8'h00;
      end else if (state == LATCH) begin
         prev_x <= rx[15:8];
         prev_y <= rx[7:0];
      end
   end
`else
   assign new_x = rx[15:8];
   assign new_y = rx[7:0];
`endif

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) state <= STARTUP;
      else        state <= state_nxt;
   end

   // cnt is cleared when a transfer ends (cs_n rises); GAP exits one cycle early so that,
   // with a request pending, cs_n is high for exactly CS_GUARD cycles (CS_GUARD >= 2).
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         STARTUP:   if (cnt == CW'(STARTUP_CYCLES - 1)) begin
                       state_nxt = INIT_XFER;
                       start     = 1'b1;
                    end
         INIT_XFER: if (xfer_done) state_nxt = GAP;
         GAP:       if (cnt == CW'(CS_GUARD - 2)) state_nxt = IDLE;
         IDLE:      if (pending || expire) begin
                       state_nxt = RD_XFER;
                       start     = 1'b1;
                    end
         RD_XFER:   if (xfer_done) state_nxt = LATCH;
         LATCH:     state_nxt = GAP;
         default:   state_nxt = STARTUP;
      endcase
   end

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         tmr          <= '0;
         div          <= '0;
         ph           <= '0;
         tx           <= '0;
         rx           <= '0;
         pending      <= 1'b0;
         spi_sclk     <= 1'b0;
         spi_mosi     <= 1'b0;
         spi_cs_n     <= 1'b1;
         accel_data_x <= 8'h00;
         accel_data_y <= 8'h00;
         data_valid   <= 1'b0;
         init_done    <= 1'b0;
      end else begin
         cnt        <= xfer_done ? '0 : cnt + CW'(1);
         data_valid <= 1'b0;

         if (!init_done || expire) tmr <= '0;
         else                      tmr <= tmr + TW'(1);

         // Expiries outside IDLE collapse into one pending request; entering a read consumes it.
         pending <= (state == IDLE) ? 1'b0 : (pending | expire);

         if (start) begin
            spi_cs_n <= 1'b0;
            spi_sclk <= 1'b0;
            spi_mosi <= frame[31];
            tx       <= frame;
            div      <= '0;
            ph       <= '0;
         end else if (xfer) begin
            if (!tick) begin
               div <= div + DW'(1);
            end else begin
               div <= '0;
               if (last_ph) begin
                  spi_cs_n <= 1'b1;
                  spi_sclk <= 1'b0;
                  spi_mosi <= 1'b0;
                  if (state == INIT_XFER) init_done <= 1'b1;
               end else begin
                  ph <= ph + 7'd1;
                  if (!ph[0]) begin
                     spi_sclk <= 1'b1;
                     rx       <= {rx[14:0], spi_miso};
                  end else begin
                     spi_sclk <= 1'b0;
                     tx       <= tx << 1;
                     spi_mosi <= tx[30];
                  end
               end
            end
         end

         if (state == LATCH) begin
            accel_data_x <= new_x;
            accel_data_y <= new_y;
            data_valid   <= 1'b1;
         end
      end
   end

endmodule
